// File: rtl/collision_ctrl_if.sv
// Bundle of scan position, sprite pixel flags and game-state outputs
// exchanged between the video pipeline and the collision/game controller.
interface collision_ctrl_if;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        CrocIn;
    logic        PlayerIn;
    logic        start;
    logic [2:0]  lives;
    logic [13:0] score;
    logic        playing;
    logic        freeze;
    logic        hit_flash;
    logic        game_over;

    // Video pipeline side: drives scan/sprite/start, observes game state.
    modport master (
        output hc, vc, CrocIn, PlayerIn, start,
        input  lives, score, playing, freeze, hit_flash, game_over
    );

    // Controller side.
    modport slave (
        input  hc, vc, CrocIn, PlayerIn, start,
        output lives, score, playing, freeze, hit_flash, game_over
    );
endinterface

// File: rtl/collision_ctrl.sv
// Croc/player collision detector and game state machine.
// Overlaps inside the visible window are accumulated over a frame and
// judged once at the end-of-frame pixel; lives, score and the
// freeze/flash/game-over controls all come straight from registers.
module collision_ctrl #(
    parameter int FRAME_HC     = 799,
    parameter int FRAME_VC     = 524,
    parameter int VIS_H0       = 144,
    parameter int VIS_H1       = 783,
    parameter int VIS_V0       = 35,
    parameter int VIS_V1       = 514,
    parameter int LIVES_INIT   = 3,
    parameter int SCORE_FRAMES = 60,
    parameter int HIT_FRAMES   = 90
) (
    input  logic            clk,
    input  logic            rst_n,
    collision_ctrl_if.slave bus
);
    localparam int FW  = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
    localparam int FZW = $clog2(HIT_FRAMES + 1);

    localparam logic [9:0]  FHC       = 10'(FRAME_HC);
    localparam logic [9:0]  FVC       = 10'(FRAME_VC);
    localparam logic [9:0]  VH0       = 10'(VIS_H0);
    localparam logic [9:0]  VH1       = 10'(VIS_H1);
    localparam logic [9:0]  VV0       = 10'(VIS_V0);
    localparam logic [9:0]  VV1       = 10'(VIS_V1);
    localparam logic [2:0]  LIVES_RST = 3'(LIVES_INIT);
    localparam logic [13:0] SCORE_MAX = 14'd9999;
    localparam logic [FW-1:0]  FRAME_LAST = FW'(SCORE_FRAMES - 1);
    localparam logic [FZW-1:0] FREEZE_RST = FZW'(HIT_FRAMES);

    typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

    state_t         state;
    logic [2:0]     livesReg;
    logic [13:0]    scoreReg;
    logic [FW-1:0]  frameCnt;
    logic [FZW-1:0] freezeCnt;
    logic           hitAcc;
    logic           playingReg;
    logic           freezeReg;
    logic           hitFlashReg;
    logic           gameOverReg;

    logic vis;
    logic overlap;
    logic eof;
    logic hitNow;

    // Pixel-level qualifiers: only visible-area overlap counts; the
    // end-of-frame pixel's own overlap joins the frame verdict.
    always_comb begin
        vis     = (bus.hc >= VH0) && (bus.hc <= VH1) &&
                  (bus.vc >= VV0) && (bus.vc <= VV1);
        overlap = bus.CrocIn & bus.PlayerIn & vis;
        eof     = (bus.hc == FHC) && (bus.vc == FVC);
        hitNow  = hitAcc | overlap;
    end

    // Game FSM with counters and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            livesReg    <= LIVES_RST;
            scoreReg    <= '0;
            frameCnt    <= '0;
            freezeCnt   <= '0;
            hitAcc      <= 1'b0;
            playingReg  <= 1'b0;
            freezeReg   <= 1'b0;
            hitFlashReg <= 1'b0;
            gameOverReg <= 1'b0;
        end else begin
            case (state)
                // Waiting for a (re)start; end-of-frame has no effect here.
                IDLE, OVER: begin
                    hitAcc <= 1'b0;
                    if (bus.start) begin
                        state       <= PLAY;
                        livesReg    <= LIVES_RST;
                        scoreReg    <= '0;
                        frameCnt    <= '0;
                        playingReg  <= 1'b1;
                        gameOverReg <= 1'b0;
                    end
                end

                PLAY: begin
                    if (eof) begin
                        hitAcc <= 1'b0;
                        if (hitNow) begin
                            playingReg <= 1'b0;
                            if (livesReg == 3'd1) begin
                                livesReg    <= 3'd0;
                                state       <= OVER;
                                gameOverReg <= 1'b1;
                            end else begin
                                // frameCnt is deliberately kept so scoring
                                // resumes mid-period after the freeze.
                                livesReg    <= livesReg - 3'd1;
                                freezeCnt   <= FREEZE_RST;
                                state       <= HIT;
                                freezeReg   <= 1'b1;
                                hitFlashReg <= 1'b0;
                            end
                        end else if (frameCnt == FRAME_LAST) begin
                            frameCnt <= '0;
                            if (scoreReg < SCORE_MAX) begin
                                scoreReg <= scoreReg + 14'd1;
                            end
                        end else begin
                            frameCnt <= frameCnt + FW'(1);
                        end
                    end else begin
                        hitAcc <= hitAcc | overlap;
                    end
                end

                // Frozen after a non-fatal hit; counts down one per frame.
                HIT: begin
                    hitAcc <= 1'b0;
                    if (eof) begin
                        if (freezeCnt == FZW'(1)) begin
                            freezeCnt   <= '0;
                            state       <= PLAY;
                            freezeReg   <= 1'b0;
                            playingReg  <= 1'b1;
                            hitFlashReg <= 1'b0;
                        end else begin
                            freezeCnt   <= freezeCnt - FZW'(1);
                            hitFlashReg <= ~hitFlashReg;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.lives     = livesReg;
    assign bus.score     = scoreReg;
    assign bus.playing   = playingReg;
    assign bus.freeze    = freezeReg;
    assign bus.hit_flash = hitFlashReg;
    assign bus.game_over = gameOverReg;
endmodule

// File: doc/collision_ctrl.md
Name: collision_ctrl

Overview:
- Downstream consumer of the per-pixel sprite flags (CrocIn from the crocodile sprite, PlayerIn from the player sprite), evaluated against the VGA scan counters hc/vc.
- Detects any croc/player overlap in the visible area during a frame and evaluates it once per frame at end-of-frame.
- Owns the game state machine, lives counter and score counter.
- Drives freeze/flash/game-over controls to the sprite and colour-mux stages.

Parameters:
FRAME_HC, 799, hc value of the last pixel clock in a line (end-of-frame column)
FRAME_VC, 524, vc value of the last line in a frame (end-of-frame row)
VIS_H0, 144, first visible hc (inclusive)
VIS_H1, 783, last visible hc (inclusive)
VIS_V0, 35, first visible vc (inclusive)
VIS_V1, 514, last visible vc (inclusive)
LIVES_INIT, 3, lives at game start (1..7)
SCORE_FRAMES, 60, PLAY frames per score point
HIT_FRAMES, 90, frames of freeze after a non-fatal hit (>=1)

Ports:
clk  in  1  pixel clock, same clock as the scan counters and sprite blocks
rst_n  in  1  asynchronous active-low reset
hc  in  10  horizontal scan counter
vc  in  10  vertical scan counter
CrocIn  in  1  current pixel lies inside the croc sprite
PlayerIn  in  1  current pixel lies inside the player sprite
start  in  1  start/restart request, level, sampled every clk
lives  out  3  remaining lives
score  out  14  score, saturates at 9999
playing  out  1  state is PLAY
freeze  out  1  state is HIT; sprite movers hold position
hit_flash  out  1  blink control during HIT
game_over  out  1  state is OVER

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, lives=LIVES_INIT, score=0, hit_acc=0, frame_cnt=0, freeze_cnt=0, all 1-bit outputs 0. All state is registered; outputs are decoded from registers (no combinational path from inputs).
- vis = (VIS_H0<=hc<=VIS_H1) && (VIS_V0<=vc<=VIS_V1).
- overlap = CrocIn & PlayerIn & vis.
- eof = (hc==FRAME_HC && vc==FRAME_VC), a one-cycle strobe per frame.
- hit_acc:
  - In PLAY, hit_acc <= hit_acc | overlap each clk.
  - The eof-cycle decision uses hit_now = hit_acc | overlap, and hit_acc clears on that same eof.
  - Overlap outside the visible area never counts.
  - hit_acc is held at 0 in IDLE, HIT and OVER.
- IDLE:
  - start=1 -> PLAY next clk. On entry: lives=LIVES_INIT, score=0, frame_cnt=0, hit_acc=0.
  - eof is ignored in IDLE, including an eof that coincides with start.
- PLAY, on eof:
  - If hit_now and lives==1: lives=0, go to OVER.
  - If hit_now and lives>1: lives=lives-1, freeze_cnt=HIT_FRAMES, go to HIT. frame_cnt is held.
  - If no hit and frame_cnt==SCORE_FRAMES-1: frame_cnt=0 and score=min(score+1, 9999).
  - If no hit otherwise: frame_cnt=frame_cnt+1.
  - start is ignored in PLAY.
- HIT:
  - freeze=1. hit_flash toggles on every eof; it is 0 on entry.
  - Each eof: freeze_cnt=freeze_cnt-1. The eof at which freeze_cnt==1 goes to PLAY with hit_flash=0 and hit_acc=0.
  - Result: exactly HIT_FRAMES eofs are spent in HIT.
  - No score accrual. start is ignored.
- OVER:
  - game_over=1. lives=0 and score are held for display.
  - start=1 -> PLAY with the same entry actions as from IDLE.
- Decode: playing=(state==PLAY), freeze=(state==HIT), game_over=(state==OVER).
- Score arithmetic: 14-bit unsigned. The value 9999 is sticky until restart; no wrap.
- Reset asserted mid-frame or mid-HIT: immediate return to the reset values. After release, the block waits in IDLE.

Test Plan:
- Reset then start pulse; run 120 frames with no overlap -> playing=1, score=2, lives=3, freeze=0.
- In PLAY, assert CrocIn&PlayerIn for 1 clk at hc=200,vc=100 -> at that frame's eof lives=2, freeze=1; hit_flash toggles each eof; freeze drops after exactly 90 eofs; score unchanged during HIT.
- Overlap only at hc=50 (outside visible area) and overlap during HIT -> no life lost in either case.
- Three separate hit frames from LIVES_INIT=3 -> third eof gives lives=0, game_over=1, score held; start -> playing=1, lives=3, score=0.
- Overlap at the eof pixel itself (hc=FRAME_HC, vc=FRAME_VC with VIS bounds widened to include it) -> hit counted on that same eof.
- Force score to 9998, run 120 frames -> score=9999 and stays there; assert rst_n=0 mid-HIT -> all outputs return to reset values immediately, asynchronously to clk.
